// File: rtl/systolic_result_collector.sv
// Result collector for the 2x2 systolic array.
// Captures the four PE accumulators on the sequencer strobes and buffers whole
// tiles in a small FIFO. Tiles drain as a row-major stream of words
// (c11, c12, c21, c22) over a valid/ready handshake. A one-cycle all_done pulse
// marks the end of a job once the sequencer's last strobe has been seen and
// every buffered tile has been delivered.
module systolic_result_collector #(
    parameter int ACC_W      = 32,
    parameter int TILE_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push11,
    input  logic             pushedge,
    input  logic             push22,
    input  logic             last,
    input  logic [ACC_W-1:0] c11,
    input  logic [ACC_W-1:0] c12,
    input  logic [ACC_W-1:0] c21,
    input  logic [ACC_W-1:0] c22,
    output logic [ACC_W-1:0] out_data,
    output logic [1:0]       out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      tile_count,
    output logic             all_done,
    output logic             overflow,
    output logic             proto_err
);

    localparam int PTR_W = (TILE_DEPTH > 1) ? $clog2(TILE_DEPTH) : 1;
    localparam int CNT_W = $clog2(TILE_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(TILE_DEPTH);

    // C_DROP / C_DROP22 follow the same strobe timing as C_EDGE / C_22 but
    // discard the tile, because the FIFO had no room when push11 arrived.
    typedef enum logic [2:0] {
        C_IDLE,
        C_EDGE,
        C_22,
        C_DROP,
        C_DROP22
    } cap_state_t;

    cap_state_t state;
    cap_state_t state_next;

    logic [ACC_W-1:0] mem [TILE_DEPTH][4];
    logic [ACC_W-1:0] cap11;
    logic [ACC_W-1:0] cap12;
    logic [ACC_W-1:0] cap21;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [1:0]       word_idx;
    logic             pending_done;

    logic xfer;
    logic pop;
    logic fifo_full;
    logic done_cond;
    logic only_edge;
    logic only_22;
    logic latch11;
    logic latch_edge;
    logic commit;
    logic set_ovf;
    logic set_err;

    // A tile slot whose last word leaves this cycle is treated as free, so a
    // push11 coinciding with the idx-3 handshake does not overflow.
    assign out_valid = (count != '0);
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && (word_idx == 2'd3);
    assign fifo_full = (count == FULL_COUNT) && !pop;
    assign only_edge = pushedge && !push11 && !push22;
    assign only_22   = push22 && !push11 && !pushedge;
    assign done_cond = pending_done && (count == '0) && (state == C_IDLE) && !out_valid;
    assign all_done  = done_cond;
    assign out_idx   = word_idx;
    assign out_data  = out_valid ? mem[rd_ptr][word_idx] : '0;

    // Capture FSM next-state and strobe decode.
    always_comb begin
        state_next = state;
        latch11    = 1'b0;
        latch_edge = 1'b0;
        commit     = 1'b0;
        set_ovf    = 1'b0;
        set_err    = 1'b0;
        case (state)
            C_IDLE: begin
                if (pushedge || push22) begin
                    set_err = 1'b1;
                end
                if (push11) begin
                    if (fifo_full) begin
                        set_ovf    = 1'b1;
                        state_next = C_DROP;
                    end else begin
                        latch11    = 1'b1;
                        state_next = C_EDGE;
                    end
                end
            end
            C_EDGE: begin
                if (only_edge) begin
                    latch_edge = 1'b1;
                    state_next = C_22;
                end else begin
                    set_err    = 1'b1;
                    state_next = C_IDLE;
                end
            end
            C_22: begin
                if (only_22) begin
                    commit = 1'b1;
                end else begin
                    set_err = 1'b1;
                end
                state_next = C_IDLE;
            end
            C_DROP: begin
                if (only_edge) begin
                    state_next = C_DROP22;
                end else begin
                    set_err    = 1'b1;
                    state_next = C_IDLE;
                end
            end
            C_DROP22: begin
                if (!only_22) begin
                    set_err = 1'b1;
                end
                state_next = C_IDLE;
            end
            default: begin
                state_next = C_IDLE;
            end
        endcase
    end

    // Capture FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= C_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Partial-tile holding registers for c11, c12 and c21.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap11 <= '0;
            cap12 <= '0;
            cap21 <= '0;
        end else begin
            if (latch11) begin
                cap11 <= c11;
            end
            if (latch_edge) begin
                cap12 <= c12;
                cap21 <= c21;
            end
        end
    end

    // Tile storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wr_ptr][0] <= cap11;
            mem[wr_ptr][1] <= cap12;
            mem[wr_ptr][2] <= cap21;
            mem[wr_ptr][3] <= c22;
        end
    end

    // FIFO pointers, occupancy and the word position within the head tile.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            word_idx <= 2'd0;
        end else begin
            if (commit) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (xfer) begin
                word_idx <= word_idx + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({commit, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Job bookkeeping: delivered-tile counter, pending end-of-job and sticky errors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tile_count   <= '0;
            pending_done <= 1'b0;
            overflow     <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            if (done_cond) begin
                tile_count   <= '0;
                pending_done <= 1'b0;
            end else begin
                if (pop) begin
                    tile_count <= tile_count + 32'd1;
                end
                if (last) begin
                    pending_done <= 1'b1;
                end
            end
            if (set_ovf) begin
                overflow <= 1'b1;
            end
            if (set_err) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_systolic_result_collector.sv
// Self-checking bench for systolic_result_collector.
// A queue-based reference model predicts the output word stream and status
// flags cycle by cycle; directed scenarios are followed by a random phase.
module tb_systolic_result_collector;

    localparam int ACC_W      = 32;
    localparam int TILE_DEPTH = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             push11;
    logic             pushedge;
    logic             push22;
    logic             last;
    logic [ACC_W-1:0] c11;
    logic [ACC_W-1:0] c12;
    logic [ACC_W-1:0] c21;
    logic [ACC_W-1:0] c22;
    logic [ACC_W-1:0] out_data;
    logic [1:0]       out_idx;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      tile_count;
    logic             all_done;
    logic             overflow;
    logic             proto_err;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: pending output words in delivery order plus job state.
    logic [ACC_W-1:0] wqData[$];
    logic [1:0]       wqIdx[$];
    int               mStage;
    bit               mDrop;
    logic [ACC_W-1:0] m11;
    logic [ACC_W-1:0] m12;
    logic [ACC_W-1:0] m21;
    logic [31:0]      mTileCount;
    bit               mPending;
    bit               mOvf;
    bit               mErr;

    systolic_result_collector #(
        .ACC_W      (ACC_W),
        .TILE_DEPTH (TILE_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .push11     (push11),
        .pushedge   (pushedge),
        .push22     (push22),
        .last       (last),
        .c11        (c11),
        .c12        (c12),
        .c21        (c21),
        .c22        (c22),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .tile_count (tile_count),
        .all_done   (all_done),
        .overflow   (overflow),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [ACC_W-1:0] rnd();
        return ACC_W'($urandom());
    endfunction

    function automatic logic pickReady(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return ($urandom_range(3) != 0);
    endfunction

    task automatic modelClear();
        wqData.delete();
        wqIdx.delete();
        mStage     = 0;
        mDrop      = 1'b0;
        mTileCount = '0;
        mPending   = 1'b0;
        mOvf       = 1'b0;
        mErr       = 1'b0;
    endtask

    task automatic checkAll();
        bit expValid;
        bit expDone;
        expValid = (wqData.size() > 0);
        expDone  = mPending && (wqData.size() == 0) && (mStage == 0);
        checkOutput("out_valid", 64'(out_valid), 64'(expValid));
        if (expValid) begin
            checkOutput("out_data", 64'(out_data), 64'(wqData[0]));
            checkOutput("out_idx", 64'(out_idx), 64'(wqIdx[0]));
        end
        checkOutput("all_done", 64'(all_done), 64'(expDone));
        checkOutput("tile_count", 64'(tile_count), 64'(mTileCount));
        checkOutput("overflow", 64'(overflow), 64'(mOvf));
        checkOutput("proto_err", 64'(proto_err), 64'(mErr));
    endtask

    // Predict the effect of one clock edge given this cycle's inputs.
    task automatic modelStep(input logic p11, input logic pe, input logic p22, input logic lst,
                             input logic rdy, input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b,
                             input logic [ACC_W-1:0] c, input logic [ACC_W-1:0] d);
        bit valid;
        bit popTile;
        bit done;
        bit full;
        int tiles;
        valid   = (wqData.size() > 0);
        popTile = valid && rdy && (wqIdx[0] == 2'd3);
        done    = mPending && (wqData.size() == 0) && (mStage == 0);
        tiles   = (wqData.size() + 3) / 4;
        full    = (tiles == TILE_DEPTH) && !popTile;
        if (valid && rdy) begin
            void'(wqData.pop_front());
            void'(wqIdx.pop_front());
        end
        if (mStage == 0) begin
            if (pe || p22) mErr = 1'b1;
            if (p11) begin
                mStage = 1;
                mDrop  = full;
                if (full) mOvf = 1'b1;
                else m11 = a;
            end
        end else if (mStage == 1) begin
            if (pe && !p11 && !p22) begin
                mStage = 2;
                m12 = b;
                m21 = c;
            end else begin
                mErr   = 1'b1;
                mStage = 0;
            end
        end else begin
            if (p22 && !p11 && !pe) begin
                if (!mDrop) begin
                    wqData.push_back(m11); wqIdx.push_back(2'd0);
                    wqData.push_back(m12); wqIdx.push_back(2'd1);
                    wqData.push_back(m21); wqIdx.push_back(2'd2);
                    wqData.push_back(d);   wqIdx.push_back(2'd3);
                end
            end else begin
                mErr = 1'b1;
            end
            mStage = 0;
        end
        if (done) begin
            mTileCount = '0;
            mPending   = 1'b0;
        end else begin
            if (popTile) mTileCount = mTileCount + 32'd1;
            if (lst) mPending = 1'b1;
        end
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model, step the clock.
    task automatic applyStimulus(input logic p11, input logic pe, input logic p22, input logic lst,
                                 input logic rdy, input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b,
                                 input logic [ACC_W-1:0] c, input logic [ACC_W-1:0] d);
        checkAll();
        push11    = p11;
        pushedge  = pe;
        push22    = p22;
        last      = lst;
        out_ready = rdy;
        c11       = a;
        c12       = b;
        c21       = c;
        c22       = d;
        modelStep(p11, pe, p22, lst, rdy, a, b, c, d);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleCycle(input int rmode, input logic lst);
        applyStimulus(1'b0, 1'b0, 1'b0, lst, pickReady(rmode), rnd(), rnd(), rnd(), rnd());
    endtask

    task automatic pushTile(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b,
                            input logic [ACC_W-1:0] c, input logic [ACC_W-1:0] d, input int rmode);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, pickReady(rmode), a, rnd(), rnd(), rnd());
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, pickReady(rmode), rnd(), b, c, rnd());
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, pickReady(rmode), rnd(), rnd(), rnd(), d);
    endtask

    // Assert reset between clock edges, check the cleared outputs, then release.
    task automatic doReset();
        reset     = 1'b1;
        push11    = 1'b0;
        pushedge  = 1'b0;
        push22    = 1'b0;
        last      = 1'b0;
        out_ready = 1'b0;
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", 64'(out_data), 64'd0);
        checkOutput("rst_out_idx", 64'(out_idx), 64'd0);
        checkOutput("rst_tile_count", 64'(tile_count), 64'd0);
        checkOutput("rst_all_done", 64'(all_done), 64'd0);
        checkOutput("rst_overflow", 64'(overflow), 64'd0);
        checkOutput("rst_proto_err", 64'(proto_err), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelClear();
    endtask

    task automatic badStrobes(output logic p11, output logic pe, output logic p22);
        case ($urandom_range(3))
            0:       begin p11 = 1'b0; pe = 1'b0; p22 = 1'b0; end
            1:       begin p11 = 1'b1; pe = 1'b0; p22 = 1'b0; end
            2:       begin p11 = 1'b0; pe = 1'b1; p22 = 1'b1; end
            default: begin p11 = 1'b1; pe = 1'b1; p22 = 1'b1; end
        endcase
    endtask

    initial begin
        logic bp11;
        logic bpe;
        logic bp22;
        reset = 1'b1;
        push11 = 1'b0; pushedge = 1'b0; push22 = 1'b0; last = 1'b0; out_ready = 1'b0;
        c11 = '0; c12 = '0; c21 = '0; c22 = '0;
        modelClear();
        @(negedge clk);
        doReset();

        $display("[TB] single tile");
        pushTile(32'd1, 32'd2, 32'd3, 32'hFFFF_FFFC, 1);
        idleCycle(1, 1'b1);
        for (int i = 0; i < 6; i++) idleCycle(1, 1'b0);

        $display("[TB] backpressure");
        pushTile(32'hA0, 32'hA1, 32'hA2, 32'hA3, 0);
        for (int i = 0; i < 5; i++) idleCycle(0, 1'b0);
        for (int i = 0; i < 10; i++) idleCycle((i % 2 == 0) ? 1 : 0, 1'b0);
        idleCycle(1, 1'b1);
        for (int i = 0; i < 3; i++) idleCycle(1, 1'b0);

        $display("[TB] back-to-back tiles");
        pushTile(32'd10, 32'd11, 32'd12, 32'd13, 0);
        pushTile(32'd20, 32'd21, 32'd22, 32'd23, 0);
        for (int i = 0; i < 10; i++) idleCycle(1, 1'b0);

        $display("[TB] overflow");
        doReset();
        pushTile(32'd30, 32'd31, 32'd32, 32'd33, 0);
        pushTile(32'd40, 32'd41, 32'd42, 32'd43, 0);
        pushTile(32'd50, 32'd51, 32'd52, 32'd53, 0);
        for (int i = 0; i < 12; i++) idleCycle(1, 1'b0);

        $display("[TB] freeing slot on push11");
        doReset();
        pushTile(32'd60, 32'd61, 32'd62, 32'd63, 0);
        pushTile(32'd70, 32'd71, 32'd72, 32'd73, 0);
        for (int i = 0; i < 3; i++) idleCycle(1, 1'b0);
        pushTile(32'd80, 32'd81, 32'd82, 32'd83, 1);
        for (int i = 0; i < 12; i++) idleCycle(1, 1'b0);

        $display("[TB] protocol error");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd90, rnd(), rnd(), rnd());
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, rnd(), rnd(), rnd(), 32'd93);
        for (int i = 0; i < 3; i++) idleCycle(1, 1'b0);
        pushTile(32'd100, 32'd101, 32'd102, 32'd103, 1);
        for (int i = 0; i < 6; i++) idleCycle(1, 1'b0);

        $display("[TB] reset mid-drain");
        doReset();
        pushTile(32'd110, 32'd111, 32'd112, 32'd113, 1);
        idleCycle(1, 1'b0);
        idleCycle(1, 1'b0);
        doReset();
        for (int i = 0; i < 4; i++) idleCycle(1, 1'b0);
        pushTile(32'd120, 32'd121, 32'd122, 32'd123, 1);
        for (int i = 0; i < 6; i++) idleCycle(1, 1'b0);

        $display("[TB] random traffic");
        doReset();
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(99);
            if (r < 55) begin
                pushTile(rnd(), rnd(), rnd(), rnd(), 2);
            end else if (r < 62) begin
                applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, pickReady(2), rnd(), rnd(), rnd(), rnd());
                badStrobes(bp11, bpe, bp22);
                applyStimulus(bp11, bpe, bp22, 1'b0, pickReady(2), rnd(), rnd(), rnd(), rnd());
            end else if (r < 68) begin
                applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, pickReady(2), rnd(), rnd(), rnd(), rnd());
                applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, pickReady(2), rnd(), rnd(), rnd(), rnd());
                badStrobes(bp11, bpe, bp22);
                if (bpe && !bp11) bp22 = 1'b0;
                applyStimulus(bp11, bpe, bp22, 1'b0, pickReady(2), rnd(), rnd(), rnd(), rnd());
            end else if (r < 71) begin
                applyStimulus(1'b0, ($urandom_range(1) == 1), 1'b1, 1'b0, pickReady(2), rnd(), rnd(), rnd(), rnd());
            end else begin
                idleCycle(2, ($urandom_range(19) == 0));
            end
        end
        for (int i = 0; i < 12; i++) idleCycle(1, 1'b0);
        idleCycle(1, 1'b1);
        for (int i = 0; i < 4; i++) idleCycle(1, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
